// File: rtl/multicycle_datapath_cu_if.sv
// ---------------------------------------------------------------------------
// multicycle_datapath_cu_if
// Bus bundle for the multi-cycle core.
//   imem_we / imem_addr / imem_wdata : instruction-memory load port (into core)
//   PC_next   : word address of the next instruction to fetch (from core)
//   finalout  : last value written to a register or to data memory (from core)
//   retire    : one-cycle pulse per completed instruction (from core)
//   halted    : high once HALT has executed, until reset (from core)
// master = the side that loads programs and observes; slave = the core.
// ---------------------------------------------------------------------------
interface multicycle_datapath_cu_if #(
   parameter int DATA_W = 32,
   parameter int IA_W   = 6
);
   logic              imem_we;
   logic [IA_W-1:0]   imem_addr;
   logic [31:0]       imem_wdata;
   logic [DATA_W-1:0] PC_next;
   logic [DATA_W-1:0] finalout;
   logic              retire;
   logic              halted;

   modport master (
      output imem_we, imem_addr, imem_wdata,
      input  PC_next, finalout, retire, halted
   );

   modport slave (
      input  imem_we, imem_addr, imem_wdata,
      output PC_next, finalout, retire, halted
   );
endinterface

// File: rtl/multicycle_datapath_cu.sv
// ---------------------------------------------------------------------------
// multicycle_datapath_cu
// Multi-cycle processor core: one ALU and one memory access per instruction,
// sequenced by a FETCH/DECODE/EXEC/MEM/WB control FSM plus a terminal HALT.
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   reset  : synchronous, active-high; restarts at PC 0
//   bus    : slave side of multicycle_datapath_cu_if (IMEM load port and
//            the registered PC_next / finalout / retire / halted outputs)
// Instruction: [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2,
//              [12:0] imm13 (sign-extended).
// ---------------------------------------------------------------------------
module multicycle_datapath_cu #(
   parameter int  DATA_W     = 32,
   parameter int  IMEM_DEPTH = 64,
   parameter int  DMEM_DEPTH = 64,
   localparam int IA_W       = $clog2(IMEM_DEPTH),
   localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_datapath_cu_if.slave  bus
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LW   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_BEQ  = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd11;

   // Architectural / control state
   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] finalout_q, finalout_d;
   logic              retire_q, retire_d;
   logic              halted_q, halted_d;

   // Registered memory read data
   logic [31:0]       ir_q;
   logic [DATA_W-1:0] a_q, b_q, mdr_q;

   // Storage
   logic [31:0]       imem_mem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem_mem [DMEM_DEPTH];
   logic [DATA_W-1:0] rf_mem   [32];

   // Decode of the latched instruction (stable from DECODE to the end)
   logic [3:0]        opcode;
   logic [4:0]        rd_sel, rs1_sel, rs2_sel;
   logic [DATA_W-1:0] imm_full;
   logic [DATA_W-1:0] a_val, b_val;
   logic [DATA_W-1:0] alu_result, wb_val, pc_plus1;
   logic [DA_W-1:0]   dmem_addr;
   logic              imem_wr_en, rf_we, dmem_we;

   assign opcode   = ir_q[31:28];
   assign rd_sel   = ir_q[27:23];
   assign rs1_sel  = ir_q[22:18];
   assign rs2_sel  = ir_q[17:13];
   assign imm_full = {{(DATA_W-13){ir_q[12]}}, ir_q[12:0]};

   // R0 is forced to zero on the read side so the array never needs clearing.
   assign a_val = (rs1_sel == 5'd0) ? '0 : a_q;
   assign b_val = (rs2_sel == 5'd0) ? '0 : b_q;

   assign pc_plus1  = pc_q + 1'b1;
   assign dmem_addr = alu_q[DA_W-1:0];
   assign wb_val    = (opcode == OP_LW) ? mdr_q : alu_q;

   // Program loading is only safe while the core is not fetching.
   assign imem_wr_en = bus.imem_we && (reset || halted_q);
   // Writes are suppressed on a reset edge so an interrupted instruction
   // leaves no architectural trace.
   assign rf_we   = (state_q == S_WB) && !reset && (rd_sel != 5'd0);
   assign dmem_we = (state_q == S_MEM) && (opcode == OP_SW) && !reset;

   always_comb begin
      alu_result = a_val + imm_full;   // ADDI and LW/SW address
      case (opcode)
         OP_ADD:  alu_result = a_val + b_val;
         OP_SUB:  alu_result = a_val - b_val;
         OP_AND:  alu_result = a_val & b_val;
         OP_OR:   alu_result = a_val | b_val;
         OP_XOR:  alu_result = a_val ^ b_val;
         OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_val) < $signed(b_val))};
         default: alu_result = a_val + imm_full;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      alu_d      = alu_q;
      finalout_d = finalout_q;
      retire_d   = 1'b0;
      halted_d   = halted_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               state_d  = S_HALT;
               pc_d     = pc_plus1;
               halted_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_d = alu_result;
            if (opcode <= OP_ADDI) begin
               state_d = S_WB;
            end else if (opcode == OP_LW || opcode == OP_SW) begin
               state_d = S_MEM;
            end else begin
               state_d  = S_FETCH;
               retire_d = 1'b1;
               if (opcode == OP_BEQ)
                  pc_d = (a_val == b_val) ? pc_plus1 + imm_full : pc_plus1;
               else if (opcode == OP_JMP)
                  pc_d = imm_full;
               else
                  pc_d = pc_plus1;
            end
         end
         S_MEM: begin
            if (opcode == OP_LW) begin
               state_d = S_WB;
            end else begin
               state_d    = S_FETCH;
               finalout_d = b_val;
               pc_d       = pc_plus1;
               retire_d   = 1'b1;
            end
         end
         S_WB: begin
            state_d    = S_FETCH;
            finalout_d = wb_val;
            pc_d       = pc_plus1;
            retire_d   = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         alu_q      <= '0;
         finalout_q <= '0;
         retire_q   <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         alu_q      <= alu_d;
         finalout_q <= finalout_d;
         retire_q   <= retire_d;
         halted_q   <= halted_d;
      end
   end

   // Instruction memory: load port plus registered fetch read.
   always_ff @(posedge clk) begin
      if (imem_wr_en)
         imem_mem[bus.imem_addr] <= bus.imem_wdata;
      if (state_q == S_FETCH && !reset)
         ir_q <= imem_mem[pc_q[IA_W-1:0]];
   end

   // Register file: operands are captured in DECODE; WB of the previous
   // instruction has already landed, so no forwarding is needed.
   always_ff @(posedge clk) begin
      if (rf_we)
         rf_mem[rd_sel] <= wb_val;
      if (state_q == S_DECODE) begin
         a_q <= rf_mem[ir_q[22:18]];
         b_q <= rf_mem[ir_q[17:13]];
      end
   end

   // Data memory: single access in MEM.
   always_ff @(posedge clk) begin
      if (dmem_we)
         dmem_mem[dmem_addr] <= b_val;
      if (state_q == S_MEM)
         mdr_q <= dmem_mem[dmem_addr];
   end

   assign bus.PC_next  = pc_q;
   assign bus.finalout = finalout_q;
   assign bus.retire   = retire_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_multicycle_datapath_cu.sv
module tb_multicycle_datapath_cu;

   logic clk;
   logic reset;

   multicycle_datapath_cu_if #(.DATA_W(32), .IA_W(6)) bus ();

   multicycle_datapath_cu #(.DATA_W(32), .IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instruction-set-level reference model
   logic [31:0] m_imem [64];
   logic [31:0] m_rf   [32];
   logic [31:0] m_dm   [64];
   logic [31:0] m_pc;
   logic [31:0] m_fin;

   logic [31:0] prog_q  [$];
   logic [31:0] obs_fin [$];
   logic [31:0] obs_pc  [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
      return {op[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm[12:0]};
   endfunction

   // Executes one instruction at m_pc; returns its cycle count.
   function automatic int model_step(output bit is_halt);
      logic [31:0] w, a, b, imm, res;
      logic [3:0]  op;
      logic [4:0]  rd, rs1, rs2;
      int          addr;
      int          cpi;
      w   = m_imem[m_pc[5:0]];
      op  = w[31:28];
      rd  = w[27:23];
      rs1 = w[22:18];
      rs2 = w[17:13];
      imm = {{19{w[12]}}, w[12:0]};
      a   = (rs1 == 0) ? 32'd0 : m_rf[rs1];
      b   = (rs2 == 0) ? 32'd0 : m_rf[rs2];
      addr = int'((a + imm) & 32'd63);
      is_halt = 1'b0;
      res = 32'd0;
      cpi = 3;
      case (op)
         4'd0: res = a + b;
         4'd1: res = a - b;
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: res = a + imm;
         4'd7: res = m_dm[addr];
         default: res = 32'd0;
      endcase
      if (op <= 4'd7) begin
         if (rd != 0) m_rf[rd] = res;
         m_fin = res;
         m_pc  = m_pc + 1;
         cpi   = (op == 4'd7) ? 5 : 4;
      end else if (op == 4'd8) begin
         m_dm[addr] = b;
         m_fin = b;
         m_pc  = m_pc + 1;
         cpi   = 4;
      end else if (op == 4'd9) begin
         m_pc = (a == b) ? m_pc + 1 + imm : m_pc + 1;
      end else if (op == 4'd10) begin
         m_pc = imm;
      end else if (op == 4'd11) begin
         m_pc = m_pc + 1;
         is_halt = 1'b1;
         cpi = 2;
      end else begin
         m_pc = m_pc + 1;
      end
      return cpi;
   endfunction

   // Writes all 64 IMEM words (program then HALT fill), mirroring into model.
   task automatic load_imem(input bit hold_reset);
      if (hold_reset) reset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         m_imem[i]      = (i < prog_q.size()) ? prog_q[i] : enc(11, 0, 0, 0, 0);
         bus.imem_we    = 1'b1;
         bus.imem_addr  = i[5:0];
         bus.imem_wdata = m_imem[i];
         @(negedge clk);
      end
      bus.imem_we = 1'b0;
   endtask

   // Releases reset (call at a negedge) and checks every retire against the model.
   task automatic run_prog(input int max_cycles);
      int edge_n, exp_edge, cpi;
      bit hlt, done;
      obs_fin.delete();
      obs_pc.delete();
      m_pc = 0; m_fin = 0; edge_n = 0; done = 0;
      cpi = model_step(hlt);
      exp_edge = cpi;
      reset = 1'b0;
      while (!done) begin
         @(posedge clk);
         edge_n++;
         @(negedge clk);
         if (edge_n == exp_edge) begin
            if (hlt) begin
               check_val("halted", {31'd0, bus.halted}, 32'd1);
               check_val("halt_pc", bus.PC_next, m_pc);
               check_val("halt_noret", {31'd0, bus.retire}, 32'd0);
               $display("halt   cycle=%0d pc=%h", edge_n, bus.PC_next);
               done = 1;
            end else begin
               check_val("retire", {31'd0, bus.retire}, 32'd1);
               check_val("finalout", bus.finalout, m_fin);
               check_val("pc_next", bus.PC_next, m_pc);
               obs_fin.push_back(bus.finalout);
               obs_pc.push_back(bus.PC_next);
               $display("retire cycle=%0d pc=%h fin=%h", edge_n, bus.PC_next, bus.finalout);
               cpi = model_step(hlt);
               exp_edge += cpi;
            end
         end else if (bus.retire || bus.halted) begin
            check_val("stray_evt", {30'd0, bus.retire, bus.halted}, 32'd0);
         end
         if (!done && edge_n >= max_cycles) begin
            check_val("timeout_edge", edge_n, exp_edge);
            done = 1;
         end
      end
   endtask

   task automatic gen_random();
      int op, idx;
      prog_q.delete();
      for (int k = 1; k < 8; k++) prog_q.push_back(enc(6, k, 0, 0, int'($urandom_range(0, 8191))));
      for (int k = 0; k < 8; k++) prog_q.push_back(enc(8, 0, 0, k, k));
      for (int n = 0; n < 30; n++) begin
         idx = prog_q.size();
         op  = int'($urandom_range(0, 14));
         if (op >= 11) op = op + 1;   // skip HALT inside the body
         case (op)
            6:  prog_q.push_back(enc(6, $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 8191)));
            7:  prog_q.push_back(enc(7, $urandom_range(0, 7), 0, 0, $urandom_range(0, 7)));
            8:  prog_q.push_back(enc(8, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7)));
            9:  prog_q.push_back(enc(9, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
            10: prog_q.push_back(enc(10, 0, 0, 0, idx + 1 + int'($urandom_range(0, 3))));
            default: prog_q.push_back(enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0));
         endcase
      end
   endtask

   initial begin
      logic [31:0] exp_fin [4];
      int n;
      reset = 1'b1;
      bus.imem_we = 1'b0;
      bus.imem_addr = '0;
      bus.imem_wdata = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      for (int i = 0; i < 64; i++) m_dm[i] = 32'd0;
      repeat (2) @(negedge clk);

      // ALU / ADDI program
      prog_q = '{enc(6, 1, 0, 0, 5), enc(6, 2, 0, 0, -3), enc(0, 3, 1, 2, 0),
                 enc(1, 4, 2, 1, 0), enc(11, 0, 0, 0, 0)};
      load_imem(1);
      run_prog(200);
      exp_fin = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFF8};
      check_val("alu_count", obs_fin.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         check_val("alu_fin", (i < obs_fin.size()) ? obs_fin[i] : 32'hDEAD_BEEF, exp_fin[i]);
      check_val("alu_halt_pc", bus.PC_next, 32'd5);

      // Reset values, taken from a halted, non-zero state
      reset = 1'b1;
      @(negedge clk);
      check_val("rst_pc", bus.PC_next, 32'd0);
      check_val("rst_fin", bus.finalout, 32'd0);
      check_val("rst_retire", {31'd0, bus.retire}, 32'd0);
      check_val("rst_halted", {31'd0, bus.halted}, 32'd0);

      // Memory program
      prog_q = '{enc(6, 1, 0, 0, 7), enc(8, 0, 0, 1, 3), enc(7, 5, 0, 0, 3),
                 enc(0, 6, 5, 0, 0), enc(11, 0, 0, 0, 0)};
      load_imem(1);
      run_prog(200);
      check_val("mem_lw_fin", (obs_fin.size() > 3) ? obs_fin[3] : 32'hDEAD_BEEF, 32'd7);

      // Branch, R0 and PC wrap program
      prog_q = '{enc(9, 0, 0, 0, 2), enc(6, 1, 0, 0, 1), enc(6, 1, 0, 0, 2),
                 enc(6, 2, 0, 0, 1), enc(9, 0, 0, 2, 5), enc(6, 0, 0, 0, 9),
                 enc(0, 3, 0, 0, 0), enc(10, 0, 0, 0, 72), enc(11, 0, 0, 0, 0)};
      load_imem(1);
      run_prog(200);
      check_val("beq_taken_pc", (obs_pc.size() > 0) ? obs_pc[0] : 32'hDEAD_BEEF, 32'd3);
      check_val("beq_ntaken_pc", (obs_pc.size() > 2) ? obs_pc[2] : 32'hDEAD_BEEF, 32'd5);
      check_val("r0_write_fin", (obs_fin.size() > 3) ? obs_fin[3] : 32'hDEAD_BEEF, 32'd9);
      check_val("r0_read_fin", (obs_fin.size() > 4) ? obs_fin[4] : 32'hDEAD_BEEF, 32'd0);
      check_val("jmp_pc", (obs_pc.size() > 5) ? obs_pc[5] : 32'hDEAD_BEEF, 32'd72);
      check_val("wrap_halt_pc", bus.PC_next, 32'd73);

      // Reset while LW sits in MEM
      reset = 1'b1;
      prog_q = '{enc(0, 6, 5, 0, 0), enc(6, 5, 0, 0, 1), enc(6, 1, 0, 0, 7),
                 enc(8, 0, 0, 1, 3), enc(7, 5, 0, 0, 3), enc(11, 0, 0, 0, 0)};
      load_imem(1);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && n < 4; c++) begin
         @(negedge clk);
         if (bus.retire) n++;
      end
      check_val("midlw_retires", n, 32'd4);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_val("midlw_pc", bus.PC_next, 32'd0);
      check_val("midlw_fin", bus.finalout, 32'd0);
      check_val("midlw_retire", {31'd0, bus.retire}, 32'd0);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n == 0; c++) begin
         @(negedge clk);
         if (bus.retire) n = 1;
      end
      check_val("midlw_restart", n, 32'd1);
      check_val("midlw_r5_kept", bus.finalout, 32'd1);
      $display("midlw  restart fin=%h", bus.finalout);

      // IMEM writes while running are ignored (JMP 0 self-loop)
      reset = 1'b1;
      prog_q = '{enc(10, 0, 0, 0, 0)};
      load_imem(1);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         bus.imem_we = 1'b1;
         bus.imem_addr = i[5:0];
         bus.imem_wdata = enc(6, 1, 0, 0, 'h55);
         @(negedge clk);
      end
      bus.imem_we = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         n = 0;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.retire) n++;
         end
         check_val("gate_retires", n, 32'd4);
         check_val("gate_pc", bus.PC_next, 32'd0);
         check_val("gate_fin", bus.finalout, 32'd0);
         check_val("gate_halted", {31'd0, bus.halted}, 32'd0);
         $display("gate   pass=%0d retires=%0d pc=%h fin=%h", pass, n, bus.PC_next, bus.finalout);
      end

      // IMEM writes after HALT are accepted and run after reset
      reset = 1'b1;
      prog_q = '{enc(6, 1, 0, 0, 'h11), enc(11, 0, 0, 0, 0)};
      load_imem(1);
      run_prog(200);
      prog_q = '{enc(6, 2, 0, 0, 'h123), enc(11, 0, 0, 0, 0)};
      load_imem(0);
      reset = 1'b1;
      @(negedge clk);
      run_prog(200);
      check_val("halt_load_fin", (obs_fin.size() > 0) ? obs_fin[0] : 32'hDEAD_BEEF, 32'h123);

      // Randomized programs
      for (int t = 0; t < 6; t++) begin
         reset = 1'b1;
         gen_random();
         load_imem(1);
         run_prog(2000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
